// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared image geometry and server state type
package lbp_pkg;

  localparam int IMG_W      = 128;
  localparam int IMG_PIXELS = IMG_W * IMG_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE,
    DONE
  } state_t;

endpackage

// File: rtl/gray_buf.sv
// rtl/gray_buf.sv - image buffer, one synchronous write port, one asynchronous read port
module gray_buf #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset; a fresh load is required after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gray_img_server.sv
// rtl/gray_img_server.sv - loads a raster gray image and serves random reads to an engine
// Optional served-read counter output req_cnt under macro GRAY_REQ_CNT_EN.
module gray_img_server
  import lbp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_done,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              finish,
  output logic              req_err
`ifdef GRAY_REQ_CNT_EN
  ,
  output logic [ADDR_W+2:0] req_cnt
`endif
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              last_px;

  assign last_px = (ptr == {ADDR_W{1'b1}});
  assign wr_en   = (state == LOAD) && load_valid;
  // A restart pulse with valid data lands its pixel at address 0.
  assign wr_addr = load_start ? '0 : ptr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_start) next_state = LOAD;
      LOAD:    if (!load_start && load_valid && last_px) next_state = SERVE;
      SERVE:   if (finish) next_state = DONE;
      DONE:    if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gray_ready <= 1'b0;
      load_done  <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      state      <= next_state;
      gray_ready <= (next_state == SERVE);
      load_done  <= (next_state == SERVE);
      if (load_start && state != SERVE)
        ptr <= (state == LOAD && load_valid) ? ADDR_W'(1) : '0;
      else if (wr_en)
        ptr <= ptr + ADDR_W'(1);
      if (load_start)
        req_err <= 1'b0;
      else if (gray_req && !gray_ready)
        req_err <= 1'b1;
    end
  end

  assign gray_data = (state == SERVE && gray_req) ? rd_data : '0;

`ifdef GRAY_REQ_CNT_EN
  logic load_entry;
  assign load_entry = (next_state == LOAD) && (state != LOAD || load_start);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      req_cnt <= '0;
    else if (load_entry)
      req_cnt <= '0;
    else if (state == SERVE && gray_req && req_cnt != '1)
      req_cnt <= req_cnt + 1'b1;
  end
`endif

  gray_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(load_data),
    .rd_addr(gray_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_gray_img_server.sv
// tb/tb_gray_img_server.sv - directed bench for gray_img_server
// Define GRAY_REQ_CNT_EN to also exercise req_cnt.
module tb_gray_img_server;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int IMG    = 16384;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start, load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_ready;
  logic [DATA_W-1:0] gray_data;
  logic              finish;
  logic              req_err;
`ifdef GRAY_REQ_CNT_EN
  logic [ADDR_W+2:0] req_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  int served = 0;

  always #5 clk = ~clk;

  gray_img_server #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_done (load_done),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .gray_ready(gray_ready),
    .gray_data (gray_data),
    .finish    (finish),
    .req_err   (req_err)
`ifdef GRAY_REQ_CNT_EN
    ,
    .req_cnt   (req_cnt)
`endif
  );

  task automatic do_read(input int addr, input logic [7:0] exp, input string name);
    @(negedge clk);
    gray_req  = 1'b1;
    gray_addr = ADDR_W'(addr);
    #1;
    checks++;
    if (gray_data !== exp) begin
      fails++;
      $display("FAIL %s: gray_data=%h expected %h", name, gray_data, exp);
    end
    @(negedge clk);
    gray_req = 1'b0;
    served++;
  endtask

  task automatic load_image(input int mult, input bit gaps, input bit restart_data);
    int i;
    int cyc;
    @(negedge clk);
    load_start = 1'b1;
    load_valid = restart_data;
    load_data  = 8'h00;
    i = restart_data ? 1 : 0;
    @(negedge clk);
    load_start = 1'b0;
    cyc = 0;
    while (i < IMG) begin
      load_valid = !(gaps && (cyc % 3 == 2));
      load_data  = 8'(i * mult);
      if (load_valid) i++;
      cyc++;
      @(posedge clk);
      #1;
      if (i == IMG - 1 && load_valid) begin
        checks++;
        if (load_done !== 1'b0) begin
          fails++;
          $display("FAIL done_early: load_done=%b expected 0", load_done);
        end
      end
      if (i == IMG) begin
        checks++;
        if (load_done !== 1'b1 || gray_ready !== 1'b1) begin
          fails++;
          $display("FAIL done_rise: load_done=%b gray_ready=%b expected 1 1", load_done, gray_ready);
        end
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    served = 0;
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_start = 0; load_valid = 0; load_data = '0;
    gray_req = 0; gray_addr = '0; finish = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({load_done, gray_ready, req_err, gray_data} !== 11'd0) begin
      fails++;
      $display("FAIL reset_state: done/ready/err/data=%b%b%b/%h expected 000/00",
               load_done, gray_ready, req_err, gray_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_req_before_load();
    @(negedge clk);
    gray_req  = 1'b1;
    gray_addr = ADDR_W'(5);
    #1;
    checks++;
    if (gray_data !== 8'h00) begin
      fails++;
      $display("FAIL data_idle: gray_data=%h expected 00", gray_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_err !== 1'b1) begin
      fails++;
      $display("FAIL req_err_set: req_err=%b expected 1", req_err);
    end
    @(negedge clk);
    gray_req = 1'b0;
  endtask

  task automatic test_full_load();
    load_image(1, 1'b0, 1'b0);
    checks++;
    if (req_err !== 1'b0) begin
      fails++;
      $display("FAIL req_err_clear: req_err=%b expected 0", req_err);
    end
    do_read(0, 8'h00, "rd0_a");
    do_read(129, 8'h81, "rd129_a");
    do_read(16383, 8'hFF, "rd16383_a");
    @(negedge clk);
    gray_addr = ADDR_W'(129);
    #1;
    checks++;
    if (gray_data !== 8'h00) begin
      fails++;
      $display("FAIL data_noreq: gray_data=%h expected 00", gray_data);
    end
  endtask

  task automatic test_finish();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++;
    if (gray_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_in_serve: gray_ready=%b expected 1", gray_ready);
    end
    do_read(77, 8'h4D, "rd77_after_start");
    @(negedge clk);
    gray_req = 1'b1; gray_addr = ADDR_W'(200); finish = 1'b1;
    #1;
    checks++;
    if (gray_data !== 8'hC8 || gray_ready !== 1'b1) begin
      fails++;
      $display("FAIL finish_read: gray_data=%h ready=%b expected c8 1", gray_data, gray_ready);
    end
    @(negedge clk);
    gray_req = 1'b0; finish = 1'b0;
    checks++;
    if (gray_ready !== 1'b0 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL finish_drop: ready=%b done=%b expected 0 0", gray_ready, load_done);
    end
    pulse_finish();
    pulse_finish();
    checks++;
    if (gray_ready !== 1'b0 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL finish_ignored: ready=%b done=%b expected 0 0", gray_ready, load_done);
    end
  endtask

  task automatic test_reset_midload();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i * 3);
      gray_req   = (i == 2500);
      @(negedge clk);
    end
    load_valid = 1'b0;
    gray_req   = 1'b1;
    gray_addr  = ADDR_W'(10);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({load_done, gray_ready, req_err, gray_data} !== 11'd0) begin
      fails++;
      $display("FAIL reset_midload: done/ready/err/data=%b%b%b/%h expected 000/00",
               load_done, gray_ready, req_err, gray_data);
    end
    @(negedge clk);
    reset    = 1'b1;
    gray_req = 1'b0;
    load_image(3, 1'b0, 1'b0);
    do_read(129, 8'h83, "rd129_x3");
    do_read(16383, 8'hFD, "rd16383_x3");
    do_read(200, 8'h58, "rd200_x3");
    pulse_finish();
  endtask

  task automatic test_gap_load();
    @(negedge clk);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h55;
    @(negedge clk);
    load_start = 1'b0;
    repeat (50) @(negedge clk);
    load_image(1, 1'b1, 1'b1);
    do_read(0, 8'h00, "rd0_gap");
    do_read(129, 8'h81, "rd129_gap");
    do_read(16383, 8'hFF, "rd16383_gap");
    do_read(5000, 8'h88, "rd5000_gap");
  endtask

`ifdef GRAY_REQ_CNT_EN
  task automatic test_req_cnt();
    @(negedge clk);
    gray_req  = 1'b1;
    gray_addr = ADDR_W'(3);
    repeat (1000 - served) @(negedge clk);
    gray_req = 1'b0;
    pulse_finish();
    gray_req = 1'b1;
    repeat (3) @(negedge clk);
    gray_req = 1'b0;
    checks++;
    if (req_cnt !== 17'd1000) begin
      fails++;
      $display("FAIL req_cnt: req_cnt=%0d expected 1000", req_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_req_before_load();
    test_full_load();
    test_finish();
    test_reset_midload();
    test_gap_load();
`ifdef GRAY_REQ_CNT_EN
    test_req_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gray_img_server.md
GRAY_IMG_SERVER -- requirements
Module: gray_img_server

Interface
REQ-001 Parameter: ADDR_W, 14, pixel address width (image is 2^ADDR_W = 16384 pixels, 128x128).
REQ-002 Parameter: DATA_W, 8, gray pixel width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: load_start  input  1  one-cycle pulse; begins image load.
REQ-006 Port: load_valid  input  1  load_data valid this cycle.
REQ-007 Port: load_data  input  DATA_W  next pixel of the raster-order image stream.
REQ-008 Port: load_done  output  1  high while a complete image is held.
REQ-009 Port: gray_req  input  1  engine read request.
REQ-010 Port: gray_addr  input  ADDR_W  engine read address.
REQ-011 Port: gray_ready  output  1  server is able to serve reads.
REQ-012 Port: gray_data  output  DATA_W  pixel at gray_addr.
REQ-013 Port: finish  input  1  engine completion flag.
REQ-014 Port: req_err  output  1  sticky: gray_req seen while gray_ready low.

Function
REQ-015 The block SHALL implement states IDLE, LOAD, SERVE and DONE.
REQ-016 IDLE -> LOAD on load_start; the write pointer SHALL clear to 0.
REQ-017 In LOAD, each load_valid cycle SHALL write load_data to buffer[ptr] and increment ptr; cycles with load_valid low SHALL hold ptr.
REQ-018 The write at ptr = 16383 SHALL move the state to SERVE on the same edge; ptr SHALL wrap to 0 and no further writes SHALL occur.
REQ-019 load_start in LOAD SHALL restart the load at ptr 0; if load_valid is also high, that pixel SHALL be written to address 0.
REQ-020 gray_ready and load_done SHALL be registered and high exactly in SERVE.
REQ-021 In SERVE with gray_req high, gray_data SHALL equal buffer[gray_addr] combinationally in the same cycle, so a requester that drives addr at edge k samples correct data at edge k+1.
REQ-022 gray_data SHALL be 0 whenever gray_req is low or the state is not SERVE; the output is never tri-stated.
REQ-023 SERVE -> DONE on the first edge where finish is high; gray_ready SHALL fall on that edge.
REQ-024 A gray_req in the finish cycle SHALL still be served.
REQ-025 In DONE, the buffer SHALL be retained; load_start SHALL go to LOAD; finish SHALL be ignored.
REQ-026 load_start in SERVE SHALL be ignored.
REQ-027 req_err SHALL set on any edge where gray_req is high and gray_ready is low; it SHALL clear only on reset or load_start.

Reset
REQ-028 Asserting reset at any time, including mid-load, SHALL force IDLE, ptr=0, gray_ready=0, load_done=0, gray_data=0 and req_err=0 asynchronously.
REQ-029 Buffer contents SHALL NOT be reset; a new load is required after reset.

Configuration
REQ-030 With macro GRAY_REQ_CNT_EN defined, the block SHALL add output req_cnt (ADDR_W+3 bits) counting served reads in SERVE.
REQ-031 req_cnt SHALL saturate at all-ones and clear on reset or on entry to LOAD.
REQ-032 Without GRAY_REQ_CNT_EN, the req_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The shared package lbp_pkg SHALL hold IMG_W=128, IMG_PIXELS=16384 and the state enum type.
REQ-034 The buffer SHALL be a sub-module gray_buf with one synchronous write port and one asynchronous read port; FSM, pointer and flags stay in the top.

Verification
REQ-035 Scenario: load pixel i = i mod 256 with continuous load_valid -> load_done rises on the edge of the 16384th write; reads at addr 0, 129 and 16383 return 0x00, 0x81 and 0xFF.
REQ-036 Scenario: load with load_valid low every third cycle -> identical buffer contents; SERVE is entered only after exactly 16384 accepted pixels.
REQ-037 Scenario: drive gray_req with addr 5 before loading -> gray_data=0, req_err=1; then load_start -> req_err=0.
REQ-038 Scenario: finish pulse in SERVE with gray_req high at addr 200 -> data buffer[200] is returned that cycle; gray_ready=0 on the next edge; later finish pulses cause no change.
REQ-039 Scenario: reset asserted after 5000 loaded pixels -> all outputs are 0 immediately; a full reload then serves correct data.
REQ-040 Scenario (GRAY_REQ_CNT_EN): 1000 served reads followed by 3 reads while not ready -> req_cnt=1000.
